// File: rtl/fu_wb_arb_pkg.sv
// Shared types for the functional-unit writeback arbiter: entry layout, source indices
// and the minimal core-configuration record the arbiter is parameterised with.
package fu_wb_arb_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        xlen_t cause;
        xlen_t tval;
        logic  valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        xlen_t                    result;
        exception_t               exception;
    } wb_entry_t;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned NrWbSrcMax;
    } cva6_cfg_t;

    localparam cva6_cfg_t CVA6_CFG_EMPTY = '{XLEN: 64, NrWbSrcMax: 8};

    localparam int unsigned WB_SRC_PUF = 0;
    localparam int unsigned WB_SRC_FPU = 1;
    localparam int unsigned WB_SRC_X   = 2;

    function automatic int unsigned popcount(input logic [7:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fu_wb_src_fifo.sv
// Per-source result FIFO: pointer-based, head entry visible combinationally so the
// arbiter can write it back and pop it in the same cycle.
module fu_wb_src_fifo
    import fu_wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    entry_t         mem_q [DEPTH];
    logic           push_en;
    logic           pop_en;

    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign push_en = push_i & ~full_o & ~flush_i;
    assign pop_en  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; an empty FIFO's head is never observed downstream.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Round-robin writeback arbiter: buffers variable-latency unit results per source and
// drains one per cycle onto the scoreboard port. FU_WB_ARB_PERF_EN adds a conflict counter.
module fu_wb_arbiter
    import fu_wb_arb_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg    = CVA6_CFG_EMPTY,
    parameter int unsigned NR_SRC     = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [NR_SRC-1:0]                     src_valid_i,
    output logic [NR_SRC-1:0]                     src_ready_o,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]  src_trans_id_i,
    input  logic [NR_SRC-1:0][XLEN-1:0]           src_result_i,
    input  exception_t [NR_SRC-1:0]               src_exception_i,
    output logic                                  wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]              wb_trans_id_o,
    output logic [XLEN-1:0]                       wb_result_o,
    output exception_t                            wb_exception_o,
    output logic [$clog2(NR_SRC)-1:0]             wb_src_o
`ifdef FU_WB_ARB_PERF_EN
    ,
    output logic [31:0]                           conflict_cnt_o
`endif
);

    localparam int unsigned SRC_W = $clog2(NR_SRC);

    if (CVA6Cfg.XLEN != XLEN) begin : g_bad_xlen
        $error("fu_wb_arbiter: core XLEN differs from the writeback entry width");
    end
    if (NR_SRC < 2 || NR_SRC > CVA6Cfg.NrWbSrcMax) begin : g_bad_nr_src
        $error("fu_wb_arbiter: NR_SRC out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fu_wb_arbiter: FIFO_DEPTH must be a power of two and at least 2");
    end

    wb_entry_t [NR_SRC-1:0] push_data;
    wb_entry_t [NR_SRC-1:0] head_data;
    logic [NR_SRC-1:0]      full;
    logic [NR_SRC-1:0]      empty;
    logic [NR_SRC-1:0]      req;
    logic [NR_SRC-1:0]      grant;
    logic [NR_SRC-1:0]      pop;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]       gnt_idx;
    logic                   gnt_found;
    logic                   wb_valid;

    for (genvar gi = 0; gi < NR_SRC; gi++) begin : g_src
        assign push_data[gi] = '{trans_id:  src_trans_id_i[gi],
                                 result:    src_result_i[gi],
                                 exception: src_exception_i[gi]};
        assign pop[gi]       = grant[gi] & ~flush_i;

        fu_wb_src_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (wb_entry_t)
        ) i_src_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (src_valid_i[gi]),
            .data_i  (push_data[gi]),
            .pop_i   (pop[gi]),
            .full_o  (full[gi]),
            .empty_o (empty[gi]),
            .data_o  (head_data[gi])
        );
    end

    // Ready comes only from registered occupancy; a same-cycle pop never raises it.
    assign src_ready_o = ~full;
    assign req         = ~empty;

    always_comb begin
        int unsigned idx;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NR_SRC; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NR_SRC) begin
                idx -= NR_SRC;
            end
            if (!gnt_found && req[idx[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[SRC_W-1:0];
            end
        end
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (gnt_found) begin
            rr_ptr_d = (gnt_idx == SRC_W'(NR_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Idle cycles drive zeros so downstream never sees stale entry data.
    assign wb_valid = gnt_found & ~flush_i;

    always_comb begin
        wb_valid_o     = wb_valid;
        wb_trans_id_o  = '0;
        wb_result_o    = '0;
        wb_exception_o = '0;
        wb_src_o       = '0;
        if (wb_valid) begin
            wb_trans_id_o  = head_data[gnt_idx].trans_id;
            wb_result_o    = head_data[gnt_idx].result;
            wb_exception_o = head_data[gnt_idx].exception;
            wb_src_o       = gnt_idx;
        end
    end

`ifdef FU_WB_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (!flush_i && popcount(8'(req)) >= 2 && conflict_cnt_q != '1) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter; perf-counter steps compile in only with FU_WB_ARB_PERF_EN.
module tb_fu_wb_arbiter;
    import fu_wb_arb_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        flush = 1'b0;
    logic [2:0]                  src_valid;
    logic [2:0]                  src_ready;
    logic [2:0][TRANS_ID_BITS-1:0] src_tid;
    logic [2:0][XLEN-1:0]        src_res;
    exception_t [2:0]            src_exc;
    logic                        wb_valid;
    logic [TRANS_ID_BITS-1:0]    wb_tid;
    logic [XLEN-1:0]             wb_res;
    exception_t                  wb_exc;
    logic [1:0]                  wb_src;
`ifdef FU_WB_ARB_PERF_EN
    logic [31:0]                 conflict_cnt;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    fu_wb_arbiter #(.NR_SRC(3), .FIFO_DEPTH(2)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .src_valid_i     (src_valid),
        .src_ready_o     (src_ready),
        .src_trans_id_i  (src_tid),
        .src_result_i    (src_res),
        .src_exception_i (src_exc),
        .wb_valid_o      (wb_valid),
        .wb_trans_id_o   (wb_tid),
        .wb_result_o     (wb_res),
        .wb_exception_o  (wb_exc),
        .wb_src_o        (wb_src)
`ifdef FU_WB_ARB_PERF_EN
        ,
        .conflict_cnt_o  (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [2:0] tid,
                          input logic [63:0] res, input logic [1:0] src);
        chk({tag, "_valid"}, 64'(wb_valid), 64'(v));
        chk({tag, "_tid"},   64'(wb_tid),   64'(tid));
        chk({tag, "_res"},   wb_res,        res);
        chk({tag, "_src"},   64'(wb_src),   64'(src));
        $display("wb %s: valid=%0d tid=%0d res=%0h src=%0d", tag, wb_valid, wb_tid, wb_res, wb_src);
    endtask

    task automatic push(input int i, input logic [2:0] id, input logic [63:0] res);
        src_valid[i] = 1'b1;
        src_tid[i]   = id;
        src_res[i]   = res;
    endtask

    task automatic clr();
        src_valid = '0;
        src_tid   = '0;
        src_res   = '0;
        src_exc   = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_wb("reset", 1'b0, 3'd0, 64'h0, 2'd0);
        chk("reset_ready", 64'(src_ready), 64'h7);
        chk("reset_exc", 64'(wb_exc.valid), 64'h0);
        nxt();
        rst_n = 1'b1;

        // Three-way contention from rr_ptr = 0
        push(0, 3'd1, 64'h11);
        push(1, 3'd2, 64'h22);
        push(2, 3'd3, 64'h33);
        src_exc[2] = '{cause: 64'd7, tval: 64'h0, valid: 1'b1};
        @(negedge clk);
        chk("3way_no_bypass", 64'(wb_valid), 64'h0);
        nxt(); clr();
        @(negedge clk); chk_wb("3way_c1", 1'b1, 3'd1, 64'h11, 2'd0);
        nxt(); @(negedge clk); chk_wb("3way_c2", 1'b1, 3'd2, 64'h22, 2'd1);
        nxt(); @(negedge clk); chk_wb("3way_c3", 1'b1, 3'd3, 64'h33, 2'd2);
        chk("3way_exc_valid", 64'(wb_exc.valid), 64'h1);
        chk("3way_exc_cause", wb_exc.cause, 64'd7);
        nxt(); @(negedge clk); chk_wb("3way_idle", 1'b0, 3'd0, 64'h0, 2'd0);

        // Single FPU source (rr_ptr back at 0)
        nxt();
        push(WB_SRC_FPU, 3'd5, 64'hDEAD);
        @(negedge clk); chk("single_c0", 64'(wb_valid), 64'h0);
        nxt(); clr();
        @(negedge clk); chk_wb("single_c1", 1'b1, 3'd5, 64'hDEAD, 2'd1);
        chk("single_exc", 64'(wb_exc.valid), 64'h0);
        nxt(); @(negedge clk); chk_wb("single_c2", 1'b0, 3'd0, 64'h0, 2'd0);

        // Wrap-around: rr_ptr = 2 with sources 0 and 2 pending
        nxt();
        push(0, 3'd4, 64'h40);
        push(2, 3'd6, 64'h60);
        nxt(); clr();
        @(negedge clk); chk_wb("wrap_c1", 1'b1, 3'd6, 64'h60, 2'd2);
        nxt(); @(negedge clk); chk_wb("wrap_c2", 1'b1, 3'd4, 64'h40, 2'd0);
        // rr_ptr should now be 1: sources 0 and 1 pending -> 1 first
        nxt();
        push(0, 3'd1, 64'h1);
        push(1, 3'd2, 64'h2);
        nxt(); clr();
        @(negedge clk); chk_wb("wrap_rr1_c1", 1'b1, 3'd2, 64'h2, 2'd1);
        nxt(); @(negedge clk); chk_wb("wrap_rr1_c2", 1'b1, 3'd1, 64'h1, 2'd0);

        // Backpressure on PUF while FPU competes (rr_ptr = 1)
        nxt();
        push(0, 3'd4, 64'hA4);
        push(1, 3'd6, 64'hB6);
        nxt();
        push(0, 3'd5, 64'hA5);
        push(1, 3'd7, 64'hB7);
        @(negedge clk);
        chk_wb("bp_c1", 1'b1, 3'd6, 64'hB6, 2'd1);
        chk("bp_c1_ready0", 64'(src_ready[0]), 64'h1);
        nxt();
        push(0, 3'd3, 64'hA3);
        push(1, 3'd1, 64'hB1);
        @(negedge clk);
        chk_wb("bp_c2", 1'b1, 3'd4, 64'hA4, 2'd0);
        chk("bp_c2_ready0", 64'(src_ready[0]), 64'h0);
        nxt(); clr();
        @(negedge clk);
        chk_wb("bp_c3", 1'b1, 3'd7, 64'hB7, 2'd1);
        chk("bp_c3_ready", 64'(src_ready), 64'h5);
        nxt(); @(negedge clk);
        chk_wb("bp_c4", 1'b1, 3'd5, 64'hA5, 2'd0);
        chk("bp_c4_ready", 64'(src_ready), 64'h7);
        nxt(); @(negedge clk); chk_wb("bp_c5", 1'b1, 3'd1, 64'hB1, 2'd1);
        nxt(); @(negedge clk); chk_wb("bp_c6", 1'b0, 3'd0, 64'h0, 2'd0);

        // Flush with four entries buffered (rr_ptr = 2)
        nxt();
        push(0, 3'd1, 64'hC0);
        push(1, 3'd2, 64'hC1);
        push(2, 3'd3, 64'hC2);
        nxt(); clr();
        push(0, 3'd4, 64'hC4);
        push(1, 3'd5, 64'hC5);
        @(negedge clk); chk_wb("fl_pre", 1'b1, 3'd3, 64'hC2, 2'd2);
        nxt(); clr();
        flush = 1'b1;
        push(2, 3'd6, 64'hC6);
        @(negedge clk);
        chk_wb("fl_cycle", 1'b0, 3'd0, 64'h0, 2'd0);
        chk("fl_cycle_ready", 64'(src_ready), 64'h4);
        nxt(); clr();
        flush = 1'b0;
        @(negedge clk);
        chk_wb("fl_after1", 1'b0, 3'd0, 64'h0, 2'd0);
        chk("fl_after_ready", 64'(src_ready), 64'h7);
        nxt();
        push(1, 3'd2, 64'hD2);
        push(2, 3'd3, 64'hD3);
        @(negedge clk); chk_wb("fl_after2", 1'b0, 3'd0, 64'h0, 2'd0);
        nxt(); clr();
        @(negedge clk); chk_wb("fl_rr0_c1", 1'b1, 3'd2, 64'hD2, 2'd1);
        nxt(); @(negedge clk); chk_wb("fl_rr0_c2", 1'b1, 3'd3, 64'hD3, 2'd2);

        // Asynchronous reset in the middle of traffic (rr_ptr = 0)
        nxt();
        push(0, 3'd1, 64'hE1);
        push(1, 3'd2, 64'hE2);
        nxt(); clr();
        @(negedge clk); chk_wb("mrst_pre", 1'b1, 3'd1, 64'hE1, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_wb("mrst_now", 1'b0, 3'd0, 64'h0, 2'd0);
        chk("mrst_ready", 64'(src_ready), 64'h7);
        nxt();
        rst_n = 1'b1;
        @(negedge clk); chk_wb("mrst_after", 1'b0, 3'd0, 64'h0, 2'd0);

`ifdef FU_WB_ARB_PERF_EN
        chk("perf_reset", 64'(conflict_cnt), 64'd0);
        nxt();
        push(0, 3'd1, 64'hF1);
        push(1, 3'd2, 64'hF2);
        push(2, 3'd3, 64'hF3);
        nxt();
        push(0, 3'd4, 64'hF4);
        push(1, 3'd5, 64'hF5);
        push(2, 3'd6, 64'hF6);
        @(negedge clk); chk("perf_c1", 64'(conflict_cnt), 64'd0);
        nxt(); clr();
        @(negedge clk); chk("perf_c2", 64'(conflict_cnt), 64'd1);
        nxt();
        flush = 1'b1;
        @(negedge clk); chk("perf_c3", 64'(conflict_cnt), 64'd2);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("perf_final", 64'(conflict_cnt), 64'd2);
        chk("perf_empty", 64'(wb_valid), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
